i2s_shift_in: RTL and testbench
===============================

I2S_SHIFT_IN -- requirements
Module: i2s_shift_in

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning bits captured per channel slot.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge; clk >= 8x bclk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  capture enable; low holds block in HUNT, no writes.
REQ-005 SHALL have port bclk  input  1  external I2S bit clock, asynchronous to clk.
REQ-006 SHALL have port lrclk  input  1  external word select; low = left, high = right.
REQ-007 SHALL have port data_in  input  1  serial data, MSB first, I2S format (MSB one bclk after lrclk edge).
REQ-008 SHALL have port fifo_full  input  1  downstream FIFO cannot accept a write.
REQ-009 SHALL have port overflow_clr  input  1  clears overflow.
REQ-010 SHALL have port fifo_left_data  output  WORD_W  last complete left sample.
REQ-011 SHALL have port fifo_right_data  output  WORD_W  last complete right sample.
REQ-012 SHALL have port fifo_write  output  1  one-clk write strobe; data valid in same cycle.
REQ-013 SHALL have port overflow  output  1  sticky: a frame was dropped on fifo_full.

Function
REQ-014 bclk, lrclk, data_in SHALL each pass a 2-flop synchronizer; bclk rising edge detected as sync2 & ~sync3.
REQ-015 On each detected bclk rise, synchronized lrclk and data_in SHALL be sampled together.
REQ-016 Slot bit counter cnt SHALL write data to word[WORD_W-1-cnt] while cnt < WORD_W, then saturate; extra bits ignored.
REQ-017 A slot with fewer than WORD_W bits SHALL be left-justified, zero-padded in LSBs.
REQ-018 When sampled lrclk differs from previous sampled lrclk, current bit SHALL be the final bit of the previous slot; the word then closes, cnt and word clear, and the next rise carries the new MSB.
REQ-019 FSM states HUNT, LEFT, RIGHT; reset and enable=0 force HUNT.
REQ-020 HUNT -> LEFT on a high-to-low lrclk transition; a low-to-high transition in HUNT SHALL be ignored; partial slots in HUNT discarded.
REQ-021 LEFT -> RIGHT on low-to-high transition; closed word stored as pending left.
REQ-022 RIGHT -> LEFT on high-to-low transition; closed word becomes right sample; frame complete.
REQ-023 On frame complete with fifo_full=0: fifo_left_data/fifo_right_data SHALL update and fifo_write pulse high exactly one clk.
REQ-024 On frame complete with fifo_full=1: no write, outputs unchanged, overflow SHALL set.
REQ-025 fifo_write SHALL assert exactly 4 clk cycles after the bclk rising edge at the pin that carries the closing bit.
REQ-026 overflow_clr SHALL clear overflow; simultaneous set and clear SHALL leave overflow set.
REQ-027 enable falling mid-frame SHALL discard the frame without writing; rising SHALL restart in HUNT.
REQ-028 lrclk changing without any bclk rise SHALL have no effect.

Reset
REQ-029 reset SHALL asynchronously force: state HUNT, cnt 0, all words 0, fifo_left_data 0, fifo_right_data 0, fifo_write 0, overflow 0, synchronizer flops 0.
REQ-030 Assertion mid-frame SHALL abort the frame; no write on release.

Structure
REQ-031 Shared package i2s_pkg SHALL hold WORD_W default and the HUNT/LEFT/RIGHT state type.
REQ-032 One sub-module SHALL exist: i2s_in_sync, a 3-bit 2-flop synchronizer with async active-high reset.

Verification
REQ-033 clk 50 MHz, bclk 3.072 MHz, left 32'hA5A5_0001, right 32'h1234_5678 -> one fifo_write per frame with those values.
REQ-034 Capture starts mid-right-slot -> first write only after first complete left+right pair; partial data never written.
REQ-035 16-bit slots, left 16'h8001 -> fifo_left_data = 32'h8001_0000.
REQ-036 fifo_full=1 over one frame boundary -> no fifo_write, overflow=1, outputs keep prior frame; overflow_clr pulse -> overflow=0.
REQ-037 reset or enable=0 asserted at bit 10 of right slot -> no write; after release, writes resume from next full frame.
REQ-038 48-bit slots, left 48'hFEDC_BA98_7654 -> fifo_left_data = 32'hFEDC_BA98.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared word width default and receiver state type
package i2s_pkg;

    localparam int WORD_W_DEF = 32;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

endpackage

// File: rtl/i2s_shift_in_if.sv
// i2s_shift_in_if: FIFO-side write bus carrying one stereo frame per strobe
interface i2s_shift_in_if
    import i2s_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
);

    logic [WORD_W-1:0] fifo_left_data;
    logic [WORD_W-1:0] fifo_right_data;
    logic              fifo_write;
    logic              fifo_full;

    modport master (
        output fifo_left_data,
        output fifo_right_data,
        output fifo_write,
        input  fifo_full
    );

    modport slave (
        input  fifo_left_data,
        input  fifo_right_data,
        input  fifo_write,
        output fifo_full
    );

endinterface

// File: rtl/i2s_in_sync.sv
// i2s_in_sync: two-flop synchronizer for the three asynchronous I2S pins
module i2s_in_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] d,
    output logic [2:0] q
);

    logic [2:0] meta;

    // two capture stages; q is the first stage safe to use in clk logic
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/i2s_shift_in.sv
// i2s_shift_in: I2S receiver assembling left/right words and writing whole frames to a FIFO
module i2s_shift_in
    import i2s_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           bclk,
    input  logic           lrclk,
    input  logic           data_in,
    input  logic           overflow_clr,
    output logic           overflow,
    i2s_shift_in_if.master fifo
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam logic [WORD_W-1:0] MSB = {1'b1, {(WORD_W-1){1'b0}}};

    logic [2:0]        sync_q;
    logic              bclk_d;
    logic              rise;
    logic              smp_v;
    logic              smp_lr;
    logic              smp_d;
    logic              prev_lr;
    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] word_n;
    logic [WORD_W-1:0] pend;
    logic [WORD_W-1:0] pend_n;
    logic [WORD_W-1:0] left;
    logic [WORD_W-1:0] left_n;
    logic [WORD_W-1:0] right;
    logic [WORD_W-1:0] right_n;
    logic [WORD_W-1:0] mask;
    logic [WORD_W-1:0] closed;
    logic              write;
    logic              write_n;
    logic              ovf_n;
    logic              act;
    logic              change;
    logic              done;

    i2s_in_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({bclk, lrclk, data_in}),
        .q     (sync_q)
    );

    assign rise = sync_q[2] & ~bclk_d;

    // third bclk stage for edge detect, and one-cycle latch of lrclk/data on each bclk rise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_d <= 1'b0;
            smp_v  <= 1'b0;
            smp_lr <= 1'b0;
            smp_d  <= 1'b0;
        end else begin
            bclk_d <= sync_q[2];
            smp_v  <= rise;
            smp_lr <= rise ? sync_q[1] : smp_lr;
            smp_d  <= rise ? sync_q[0] : smp_d;
        end
    end

    // slot assembly and frame state; lrclk history is tracked even when disabled so re-enable sees no false edge
    always_comb begin
        act     = enable & smp_v;
        change  = act & (smp_lr != prev_lr);
        mask    = (cnt < CNT_W'(WORD_W)) ? MSB >> cnt : '0;
        closed  = smp_d ? word | mask : word;
        done    = change & (state == RIGHT);
        state_n = state;
        pend_n  = pend;
        cnt_n   = change ? '0 : (act && mask != '0) ? cnt + 1'b1 : cnt;
        word_n  = change ? '0 : act ? closed : word;
        if (change) begin
            case (state)
                HUNT:    state_n = smp_lr ? HUNT : LEFT;
                LEFT: begin
                    state_n = RIGHT;
                    pend_n  = closed;
                end
                RIGHT:   state_n = LEFT;
                default: state_n = HUNT;
            endcase
        end
        if (!enable) begin
            state_n = HUNT;
            cnt_n   = '0;
            word_n  = '0;
        end
        write_n = done & ~fifo.fifo_full;
        left_n  = write_n ? pend : left;
        right_n = write_n ? closed : right;
        ovf_n   = (done & fifo.fifo_full) | (overflow & ~overflow_clr);
    end

    // state, word and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= HUNT;
            cnt      <= '0;
            word     <= '0;
            pend     <= '0;
            left     <= '0;
            right    <= '0;
            write    <= 1'b0;
            overflow <= 1'b0;
            prev_lr  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            word     <= word_n;
            pend     <= pend_n;
            left     <= left_n;
            right    <= right_n;
            write    <= write_n;
            overflow <= ovf_n;
            prev_lr  <= smp_v ? smp_lr : prev_lr;
        end
    end

    assign fifo.fifo_left_data  = left;
    assign fifo.fifo_right_data = right;
    assign fifo.fifo_write      = write;

endmodule

// File: tb/tb_i2s_shift_in.sv
// tb_i2s_shift_in: table, hand-sequence and randomized checks of the I2S receiver against a slot-level model
module tb_i2s_shift_in;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic bclk = 1'b0;
    logic lrclk = 1'b0;
    logic data_in = 1'b0;
    logic overflow_clr = 1'b0;
    logic overflow;

    i2s_shift_in_if #(.WORD_W(32)) bus ();

    i2s_shift_in #(.WORD_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .data_in      (data_in),
        .overflow_clr (overflow_clr),
        .overflow     (overflow),
        .fifo         (bus)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_rise = 0;
    int rd = 0;
    int ovf_cnt = 0;
    int dbl = 0;
    logic prev_w = 1'b0;
    logic [31:0] wl[$];
    logic [31:0] wr[$];
    int lat[$];
    logic [31:0] el_q[$];
    logic [31:0] er_q[$];

    typedef struct {
        int          nl;
        logic [63:0] vl;
        int          nr;
        logic [63:0] vr;
        logic [31:0] el;
        logic [31:0] er;
    } vec_t;

    vec_t tbl[6];

    // cycle counter used to time fifo_write against the driving bclk rise
    always @(posedge clk) cyc <= cyc + 1;

    // record every write, its latency from the last bclk rise, and overflow activity
    always @(negedge clk) begin
        if (bus.fifo_write) begin
            wl.push_back(bus.fifo_left_data);
            wr.push_back(bus.fifo_right_data);
            lat.push_back(cyc - last_rise);
        end
        if (bus.fifo_write && prev_w) dbl++;
        prev_w = bus.fifo_write;
        if (overflow) ovf_cnt++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] just(input logic [63:0] v, input int n);
        return n >= 32 ? 32'(v >> (n - 32)) : 32'(v << (32 - n));
    endfunction

    task automatic rise_bit(input logic lr, input logic d);
        bclk = 1'b0;
        lrclk = lr;
        data_in = d;
        repeat ($urandom_range(4, 6)) @(negedge clk);
        bclk = 1'b1;
        last_rise = cyc;
        repeat ($urandom_range(4, 6)) @(negedge clk);
    endtask

    task automatic send_range(input logic lr, input int n, input logic [63:0] v, input int lo, input int hi);
        for (int i = lo; i < hi; i++) rise_bit(i == n - 1 ? ~lr : lr, v[n-1-i]);
    endtask

    task automatic send_slot(input logic lr, input int n, input logic [63:0] v);
        send_range(lr, n, v, 0, n);
    endtask

    task automatic do_reset(input logic lr0);
        @(negedge clk);
        reset = 1'b1;
        bclk = 1'b0;
        lrclk = lr0;
        data_in = 1'b0;
        enable = 1'b1;
        bus.fifo_full = 1'b0;
        overflow_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_writes(input string nm);
        repeat (20) @(negedge clk);
        chk({nm, "_count"}, 64'(wl.size() - rd), 64'(el_q.size()));
        for (int i = 0; i < el_q.size() && rd + i < wl.size(); i++) begin
            chk({nm, "_left"}, 64'(wl[rd+i]), 64'(el_q[i]));
            chk({nm, "_right"}, 64'(wr[rd+i]), 64'(er_q[i]));
            chk({nm, "_latency"}, 64'(lat[rd+i]), 64'd4);
        end
        rd = wl.size();
        el_q.delete();
        er_q.delete();
    endtask

    initial begin
        int sn[8];
        logic [63:0] sv[8];
        logic sl[8];
        int ns;
        int o0;
        logic l0;
        bus.fifo_full = 1'b0;
        tbl[0] = '{32, 64'hA5A5_0001, 32, 64'h1234_5678, 32'hA5A5_0001, 32'h1234_5678};
        tbl[1] = '{16, 64'h8001, 16, 64'hABCD, 32'h8001_0000, 32'hABCD_0000};
        tbl[2] = '{48, 64'hFEDC_BA98_7654, 48, 64'h0123_4567_89AB, 32'hFEDC_BA98, 32'h0123_4567};
        tbl[3] = '{24, 64'h12_3456, 40, 64'hFF_00FF_00FF, 32'h1234_5600, 32'hFF00_FF00};
        tbl[4] = '{33, 64'h1_FFFF_FFFE, 2, 64'h2, 32'hFFFF_FFFF, 32'h8000_0000};
        tbl[5] = '{32, 64'h0, 32, 64'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};

        do_reset(1'b1);
        chk("reset_left", 64'(bus.fifo_left_data), 64'd0);
        chk("reset_right", 64'(bus.fifo_right_data), 64'd0);
        chk("reset_write", 64'(bus.fifo_write), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);

        // table vectors: each preceded by a partial right slot
        for (int i = 0; i < 6; i++) begin
            do_reset(1'b1);
            el_q.push_back(tbl[i].el);
            er_q.push_back(tbl[i].er);
            send_slot(1'b1, 32, 64'hDEAD_BEEF);
            send_slot(1'b0, tbl[i].nl, tbl[i].vl);
            send_slot(1'b1, tbl[i].nr, tbl[i].vr);
            check_writes($sformatf("vec%0d", i));
        end

        // overflow: dropped frame, clear, then set and clear in the same cycle
        do_reset(1'b1);
        send_slot(1'b1, 32, 64'h5555_5555);
        send_slot(1'b0, 32, 64'h1111_1111);
        send_slot(1'b1, 32, 64'h2222_2222);
        el_q.push_back(32'h1111_1111);
        er_q.push_back(32'h2222_2222);
        check_writes("ovf_first");
        bus.fifo_full = 1'b1;
        send_slot(1'b0, 32, 64'h3333_3333);
        send_slot(1'b1, 32, 64'h4444_4444);
        check_writes("ovf_drop");
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_keep_left", 64'(bus.fifo_left_data), 64'h1111_1111);
        chk("ovf_keep_right", 64'(bus.fifo_right_data), 64'h2222_2222);
        bus.fifo_full = 1'b0;
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        chk("ovf_clr", 64'(overflow), 64'd0);
        o0 = ovf_cnt;
        overflow_clr = 1'b1;
        bus.fifo_full = 1'b1;
        send_slot(1'b0, 32, 64'h6666_6666);
        send_slot(1'b1, 32, 64'h7777_7777);
        repeat (10) @(negedge clk);
        chk("ovf_simul_set", 64'(ovf_cnt - o0), 64'd1);
        chk("ovf_simul_after", 64'(overflow), 64'd0);
        overflow_clr = 1'b0;
        bus.fifo_full = 1'b0;
        send_slot(1'b0, 32, 64'h8888_8888);
        send_slot(1'b1, 32, 64'h9999_9999);
        el_q.push_back(32'h8888_8888);
        er_q.push_back(32'h9999_9999);
        check_writes("ovf_resume");

        // enable dropped at bit 10 of the right slot, plus an lrclk glitch with bclk idle
        do_reset(1'b1);
        send_slot(1'b1, 32, 64'h5555_5555);
        send_slot(1'b0, 32, 64'hAAAA_0000);
        send_range(1'b1, 32, 64'hBBBB_0000, 0, 10);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        send_range(1'b1, 32, 64'hBBBB_0000, 10, 32);
        send_range(1'b0, 32, 64'hC0DE_CAFE, 0, 16);
        lrclk = ~lrclk;
        repeat (3) @(negedge clk);
        lrclk = ~lrclk;
        send_range(1'b0, 32, 64'hC0DE_CAFE, 16, 32);
        send_slot(1'b1, 32, 64'h0BAD_F00D);
        el_q.push_back(32'hC0DE_CAFE);
        er_q.push_back(32'h0BAD_F00D);
        check_writes("enable_abort");

        // reset pulse at bit 10 of the right slot
        do_reset(1'b1);
        send_slot(1'b1, 32, 64'h5555_5555);
        send_slot(1'b0, 32, 64'h0102_0304);
        send_slot(1'b1, 32, 64'h0506_0708);
        el_q.push_back(32'h0102_0304);
        er_q.push_back(32'h0506_0708);
        check_writes("rst_first");
        send_slot(1'b0, 32, 64'hAAAA_AAAA);
        send_range(1'b1, 32, 64'hBBBB_BBBB, 0, 10);
        reset = 1'b1;
        #1;
        chk("rst_async_left", 64'(bus.fifo_left_data), 64'd0);
        chk("rst_async_right", 64'(bus.fifo_right_data), 64'd0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        send_range(1'b1, 32, 64'hBBBB_BBBB, 10, 32);
        send_slot(1'b0, 32, 64'hCAFE_0001);
        send_slot(1'b1, 32, 64'hCAFE_0002);
        el_q.push_back(32'hCAFE_0001);
        er_q.push_back(32'hCAFE_0002);
        check_writes("rst_abort");

        // randomized slot streams against the slot-level model
        for (int it = 0; it < 5; it++) begin
            ns = $urandom_range(5, 8);
            l0 = 1'($urandom_range(0, 1));
            for (int s = 0; s < ns; s++) begin
                sn[s] = $urandom_range(2, 48);
                sv[s] = {$urandom, $urandom} & ((64'd1 << sn[s]) - 64'd1);
                sl[s] = l0 ^ s[0];
            end
            for (int k = 1; k + 1 < ns; k++) begin
                if (!sl[k]) begin
                    el_q.push_back(just(sv[k], sn[k]));
                    er_q.push_back(just(sv[k+1], sn[k+1]));
                end
            end
            do_reset(l0);
            for (int s = 0; s < ns; s++) send_slot(sl[s], sn[s], sv[s]);
            check_writes($sformatf("rand%0d", it));
        end

        chk("write_pulse_width", 64'(dbl), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
